// File: rtl/pressure_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pressure_pkg
//  Description : Shared types and constants for the pressure alarm slice.
//                Provides the alarm FSM state encoding and the widths of the
//                pressure code and the alarm event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pressure_pkg;

    // Width of the raw pressure code from the analyzer
    localparam int PDATA_W = 5;
    // Width of the alarm event counter
    localparam int EVT_W   = 8;

    // Alarm FSM states. The encoding is visible on the `state` port, and
    // bit 1 is the alarm-active flag (ALARM and CLEARING).
    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_PENDING  = 2'd1,
        ST_ALARM    = 2'd2,
        ST_CLEARING = 2'd3
    } alarm_state_t;

endpackage : pressure_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with increment enable that saturates at
//                all-ones. Synchronous active-high reset clears it.
//  Ports       : clk   - system clock (rising edge)
//                rst   - synchronous active-high reset
//                inc   - increment request for this cycle
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pressure_alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pressure_alarm_controller
//  Description : Qualifies analyzer warnings with a trip streak, raises a
//                latched alarm held until operator acknowledge, and drops it
//                after a clean recovery streak. Counts alarm entries and
//                records the last out-of-range pressure code.
//  Ports       : clk            - system clock (rising edge)
//                rst            - synchronous active-high reset
//                sample_valid   - pData/pWarning carry a new sample
//                pData          - raw pressure code 0..31
//                pWarning       - analyzer verdict for pData
//                ack            - operator acknowledge (honoured in ALARM)
//                alarm          - alarm active (ALARM or CLEARING)
//                alarm_pending  - warning streak in progress (PENDING)
//                state          - FSM state: 0 NORMAL,1 PENDING,2 ALARM,3 CLEARING
//                event_count    - ALARM entries since reset, saturating
//                last_bad_value - pData of the most recent warning sample
//  Revision    : 1.0 - initial release
// ============================================================================
module pressure_alarm_controller
    import pressure_pkg::*;
#(
    parameter int TRIP_COUNT  = 3,
    parameter int CLEAR_COUNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [PDATA_W-1:0] pData,
    input  logic               pWarning,
    input  logic               ack,
    output logic               alarm,
    output logic               alarm_pending,
    output logic [1:0]         state,
    output logic [EVT_W-1:0]   event_count,
    output logic [PDATA_W-1:0] last_bad_value
);

    localparam logic [3:0] c_trip_count  = 4'(TRIP_COUNT);
    localparam logic [3:0] c_clear_count = 4'(CLEAR_COUNT);

    alarm_state_t       r_state;
    logic [3:0]         r_cnt;
    logic [PDATA_W-1:0] r_last_bad;

    logic               w_warn_sample;
    logic               w_clean_sample;
    logic [3:0]         w_cnt_next;
    logic               w_trip;

    assign w_warn_sample  = sample_valid &  pWarning;
    assign w_clean_sample = sample_valid & ~pWarning;
    // Streak never exceeds 14 before it is compared, so 4 bits cannot wrap.
    assign w_cnt_next     = r_cnt + 4'd1;

    // Final warning of a trip streak: drives both the FSM and event counter.
    assign w_trip = (r_state == ST_PENDING) && w_warn_sample &&
                    (w_cnt_next == c_trip_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_NORMAL;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_warn_sample) begin
                        r_state <= ST_PENDING;
                        r_cnt   <= 4'd1;
                    end else begin
                        r_cnt   <= 4'd0;
                    end
                end
                ST_PENDING: begin
                    if (w_trip) begin
                        r_state <= ST_ALARM;
                        r_cnt   <= 4'd0;
                    end else if (w_warn_sample) begin
                        r_cnt   <= w_cnt_next;
                    end else if (w_clean_sample) begin
                        r_state <= ST_NORMAL;
                        r_cnt   <= 4'd0;
                    end
                end
                ST_ALARM: begin
                    // Samples are ignored here; a clean sample arriving with
                    // the ack already counts towards the recovery streak.
                    if (ack) begin
                        r_state <= ST_CLEARING;
                        r_cnt   <= w_clean_sample ? 4'd1 : 4'd0;
                    end
                end
                ST_CLEARING: begin
                    if (w_clean_sample) begin
                        if (w_cnt_next == c_clear_count) begin
                            r_state <= ST_NORMAL;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt   <= w_cnt_next;
                        end
                    end else if (w_warn_sample) begin
                        r_cnt   <= 4'd0;
                    end
                end
                default: begin
                    r_state <= ST_NORMAL;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_bad <= '0;
        end else if (w_warn_sample) begin
            r_last_bad <= pData;
        end
    end

    sat_counter #(
        .WIDTH (EVT_W)
    ) u_event_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_trip),
        .count (event_count)
    );

    assign state          = r_state;
    assign alarm          = r_state[1];
    assign alarm_pending  = (r_state == ST_PENDING);
    assign last_bad_value = r_last_bad;

endmodule : pressure_alarm_controller
`default_nettype wire

// File: tb/tb_pressure_alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pressure_alarm_controller
//  Description : Self-checking bench for pressure_alarm_controller. A
//                behavioural model tracks mode, streak length, alarm count
//                and last bad code; every cycle the DUT outputs are compared
//                against it, plus literal expectations for directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pressure_alarm_controller;

    localparam int TRIP  = 3;
    localparam int CLEAR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [4:0] pData = 5'd0;
    logic       pWarning = 1'b0;
    logic       ack = 1'b0;
    logic       alarm;
    logic       alarm_pending;
    logic [1:0] state;
    logic [7:0] event_count;
    logic [4:0] last_bad_value;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Model: mode 0 normal, 1 pending, 2 alarm (unacked), 3 recovering
    int m_mode   = 0;
    int m_streak = 0;
    int m_events = 0;
    int m_last   = 0;

    pressure_alarm_controller #(
        .TRIP_COUNT  (TRIP),
        .CLEAR_COUNT (CLEAR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .pData          (pData),
        .pWarning       (pWarning),
        .ack            (ack),
        .alarm          (alarm),
        .alarm_pending  (alarm_pending),
        .state          (state),
        .event_count    (event_count),
        .last_bad_value (last_bad_value)
    );

    always #5 clk = ~clk;

    function automatic logic warn_of(input logic [4:0] d);
        return (d < 5'd8) || (d > 5'd22);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour, evaluated on each rising edge from the inputs
    // that were set up during the previous cycle.
    always @(posedge clk) begin
        bit v, w, a;
        v = sample_valid;
        w = pWarning;
        a = ack;
        if (rst) begin
            m_mode = 0; m_streak = 0; m_events = 0; m_last = 0;
        end else begin
            if (v && w) m_last = int'(pData);
            if (m_mode == 0) begin
                if (v && w) begin m_mode = 1; m_streak = 1; end
                else m_streak = 0;
            end else if (m_mode == 1) begin
                if (v && w) begin
                    if (m_streak + 1 == TRIP) begin
                        m_mode = 2; m_streak = 0;
                        m_events = (m_events < 255) ? m_events + 1 : 255;
                    end else m_streak = m_streak + 1;
                end else if (v) begin
                    m_mode = 0; m_streak = 0;
                end
            end else if (m_mode == 2) begin
                if (a) begin
                    m_mode = 3;
                    m_streak = (v && !w) ? 1 : 0;
                end
            end else begin
                if (v && !w) begin
                    if (m_streak + 1 == CLEAR) begin m_mode = 0; m_streak = 0; end
                    else m_streak = m_streak + 1;
                end else if (v) m_streak = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state",          int'(state),          m_mode);
            chk("alarm",          int'(alarm),          (m_mode >= 2) ? 1 : 0);
            chk("alarm_pending",  int'(alarm_pending),  (m_mode == 1) ? 1 : 0);
            chk("event_count",    int'(event_count),    m_events);
            chk("last_bad_value", int'(last_bad_value), m_last);
        end
    end

    task automatic step(input logic v, input logic [4:0] d, input logic a);
        sample_valid = v;
        pData        = d;
        pWarning     = warn_of(d);
        ack          = a;
        @(posedge clk);
        #1;
    endtask

    task automatic trip();
        step(1'b1, 5'd5, 1'b0);
        step(1'b1, 5'd6, 1'b0);
        step(1'b1, 5'd30, 1'b0);
    endtask

    task automatic recover();
        step(1'b0, 5'd0, 1'b1);
        for (int i = 0; i < CLEAR; i++) step(1'b1, 5'd15, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 1'b0);
        cmp_en = 1'b1;
        chk("reset_state", int'(state), 0);
        chk("reset_events", int'(event_count), 0);
        chk("reset_last", int'(last_bad_value), 0);
        rst = 1'b0;

        // Trip streak 5,6,30
        step(1'b1, 5'd5, 1'b0);
        chk("pending_after_first", int'(state), 1);
        step(1'b0, 5'd0, 1'b0);          // gap must not break the streak
        step(1'b1, 5'd6, 1'b0);
        step(1'b1, 5'd30, 1'b0);
        chk("alarm_after_third", int'(alarm), 1);
        chk("events_first_trip", int'(event_count), 1);
        chk("last_bad_30", int'(last_bad_value), 30);

        // No ack: clean samples leave the alarm latched
        for (int i = 0; i < 10; i++) step(1'b1, 5'd15, 1'b0);
        chk("latched_alarm", int'(state), 2);
        step(1'b1, 5'd15, 1'b1);         // ack with a clean sample = clean #1
        chk("clearing_after_ack", int'(state), 3);
        step(1'b1, 5'd15, 1'b1);         // held ack is harmless
        step(1'b1, 5'd15, 1'b0);
        chk("still_clearing", int'(alarm), 1);
        step(1'b1, 5'd15, 1'b0);
        chk("normal_after_4_clean", int'(state), 0);

        // W,W,clean,W
        step(1'b1, 5'd2, 1'b0);
        step(1'b1, 5'd25, 1'b0);
        step(1'b1, 5'd12, 1'b0);
        chk("clean_breaks_streak", int'(state), 0);
        step(1'b1, 5'd3, 1'b0);
        chk("restart_pending", int'(state), 1);
        step(1'b1, 5'd12, 1'b0);
        chk("no_alarm_events", int'(event_count), 1);

        // Warn inside CLEARING restarts the recovery streak
        trip();
        step(1'b0, 5'd0, 1'b1);
        step(1'b1, 5'd15, 1'b0);
        step(1'b1, 5'd15, 1'b0);
        step(1'b1, 5'd23, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 5'd15, 1'b0);
        chk("clearing_after_3_post_warn", int'(state), 3);
        step(1'b1, 5'd15, 1'b0);
        chk("normal_after_4_post_warn", int'(alarm), 0);
        chk("last_bad_23", int'(last_bad_value), 23);

        // Reset mid-alarm
        rst = 1'b1;
        step(1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        trip();
        recover();
        trip();
        chk("alarm_evt2", int'(event_count), 2);
        rst = 1'b1;
        step(1'b1, 5'd4, 1'b0);
        rst = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_events", int'(event_count), 0);
        chk("rst_last", int'(last_bad_value), 0);

        // Saturation after 256 trips
        for (int i = 0; i < 256; i++) begin
            trip();
            recover();
        end
        chk("events_saturated", int'(event_count), 255);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic v, a;
            logic [4:0] d;
            rst = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 7);
            a = ($urandom_range(0, 9) == 0);
            d = 5'($urandom_range(0, 31));
            step(v, d, a);
        end
        rst = 1'b0;
        step(1'b0, 5'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pressure_alarm_controller
`default_nettype wire

// File: doc/pressure_alarm_controller.md
# pressure_alarm_controller

Downstream consumer of the pressure analyzer's combinational `pWarning`. It qualifies warnings per sample with a trip streak, raises a latched `alarm` that stays up until an operator acknowledges it, and drops the alarm only after a clean recovery streak. It also counts alarm events and records the last out-of-range reading for the display stage.

## Interface
- `TRIP_COUNT`, default 3: consecutive warning samples needed to raise the alarm. Legal range 2..15.
- `CLEAR_COUNT`, default 4: consecutive clean samples needed after ack to drop the alarm. Legal range 2..15.

Ports:
- `clk` input 1: single system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sample_valid` input 1: `pData`/`pWarning` hold a new sample this cycle; one sample per high cycle.
- `pData` input 5: raw pressure code, unsigned 0..31.
- `pWarning` input 1: analyzer verdict for `pData` (high when code <8 or >22).
- `ack` input 1: operator acknowledge, sampled every cycle.
- `alarm` output 1: alarm active (states ALARM and CLEARING).
- `alarm_pending` output 1: high in state PENDING.
- `state` output 2: NORMAL=0, PENDING=1, ALARM=2, CLEARING=3.
- `event_count` output 8: number of ALARM entries since reset; saturates at 255.
- `last_bad_value` output 5: `pData` of the most recent warning sample.

## Operation
- Only `sample_valid` cycles advance the streak logic. `ack` is honoured only in ALARM and is ignored in every other state.
- Internal streak counter `cnt`, 4 bits.
- Transitions in NORMAL:
  - valid & warn: `cnt`=1, go to PENDING.
  - otherwise: stay, `cnt`=0.
- Transitions in PENDING:
  - valid & warn: if `cnt`+1==`TRIP_COUNT`, go to ALARM, `cnt`=0, `event_count`+1 (saturating). Else `cnt`+1.
  - valid & !warn: go to NORMAL, `cnt`=0.
  - no valid: hold.
- Transitions in ALARM:
  - Samples do not change state.
  - `ack`=1: go to CLEARING. `cnt` = 1 if (valid & !warn) that cycle, else 0.
- Transitions in CLEARING (no re-ack required):
  - valid & !warn: if `cnt`+1==`CLEAR_COUNT`, go to NORMAL, `cnt`=0. Else `cnt`+1.
  - valid & warn: stay, `cnt`=0.
  - no valid: hold.
- `last_bad_value` loads `pData` on every valid & warn cycle, in any state.
- `event_count` never wraps; it holds at 255.

## Timing
- All outputs are registered. Any effect of a sample or `ack` is visible in the cycle after it is presented.
- Reset values: state NORMAL, `alarm`=0, `alarm_pending`=0, `event_count`=0, `last_bad_value`=0, `cnt`=0.
- Latency to alarm: `alarm` rises on the cycle after the `TRIP_COUNT`-th consecutive valid warning sample. Gaps in `sample_valid` do not break a streak.
- `alarm` is combinationally decoded from the registered state: `alarm = state[1]`, `alarm_pending = (state==1)`.
- Simultaneous `ack` and valid sample in ALARM: the sample counts as the first CLEARING sample, as specified under Operation.
- `rst` mid-alarm: the next cycle shows reset values, and `event_count` is cleared.
- A multi-cycle `ack` level is harmless: after the first cycle the block is already in CLEARING.

## Structure
- Shared package `pressure_pkg`:
  - state enum `alarm_state_t` (2 bits)
  - constant `PDATA_W`=5
  - constant `EVT_W`=8
- Natural sub-module: `sat_counter`, a parameterised width with increment enable, saturating at all-ones and cleared by `rst`. Used for `event_count`.
- The FSM and streak counter stay in the top module.

## Test plan
- Reset, then 3 valid samples with `pWarning`=1 and `pData`=5,6,30 → PENDING after the first; `alarm`=1 after the third; `event_count`=1; `last_bad_value`=30.
- Warnings W,W, then one clean sample, then W → state returns to NORMAL after the clean sample; no alarm; `event_count`=0.
- Alarm raised, no ack, then 10 clean samples → `alarm` stays 1 and state stays ALARM. Then `ack` with a clean sample, then 3 more clean samples → NORMAL after the 4th clean sample counted.
- In CLEARING, clean, clean, warn (`pData`=23), then 4 clean → `cnt` resets on the warn; `alarm` drops only after the 4th post-warn clean sample; `last_bad_value`=23.
- Trip the alarm 256 times → `event_count` holds at 255.
- Assert `rst` while in ALARM with `event_count`=2 → next cycle: NORMAL, `alarm`=0, `event_count`=0, `last_bad_value`=0.
